// File: rtl/fir_coeff_ctrl.sv
// Coefficient update controller for a FIR filter: shadows a new coefficient
// set, then swaps it in on a sample boundary with the filter frozen.
module fir_coeff_ctrl #(
    parameter int ORDER           = 15,
    parameter int COEFF_WIDTH     = 32,
    parameter int FLUSH_ON_UPDATE = 1,
    localparam int AW = (ORDER > 1) ? $clog2(ORDER) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_start,
    input  logic                   cfg_abort,
    input  logic [COEFF_WIDTH-1:0] cfg_coeff_data,
    input  logic                   cfg_coeff_valid,
    output logic                   cfg_coeff_ready,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    input  logic                   sample_strobe,
    output logic                   filter_enable,
    output logic                   filter_flush,
    output logic                   coef_wr_en,
    output logic [AW-1:0]          coef_wr_addr,
    output logic [COEFF_WIDTH-1:0] coef_wr_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_SAMPLE,
        WRITE,
        FLUSH,
        DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(ORDER - 1);

    state_t                 state;
    logic [AW-1:0]          count;
    logic [COEFF_WIDTH-1:0] shadow [ORDER];
    logic [AW-1:0]          next_addr;

    assign next_addr = coef_wr_addr + AW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            count           <= '0;
            for (int i = 0; i < ORDER; i++) shadow[i] <= '0;
            cfg_coeff_ready <= 1'b0;
            cfg_busy        <= 1'b0;
            cfg_done        <= 1'b0;
            filter_enable   <= 1'b1;
            filter_flush    <= 1'b0;
            coef_wr_en      <= 1'b0;
            coef_wr_addr    <= '0;
            coef_wr_data    <= '0;
        end else begin
            // Pulse outputs and the write bus idle at zero unless set below
            cfg_done     <= 1'b0;
            filter_flush <= 1'b0;
            coef_wr_en   <= 1'b0;
            coef_wr_addr <= '0;
            coef_wr_data <= '0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state           <= LOAD;
                        count           <= '0;
                        cfg_coeff_ready <= 1'b1;
                        cfg_busy        <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_abort) begin
                        state           <= IDLE;
                        count           <= '0;
                        cfg_coeff_ready <= 1'b0;
                        cfg_busy        <= 1'b0;
                    end else if (cfg_coeff_valid) begin
                        shadow[count] <= cfg_coeff_data;
                        if (count == LAST) begin
                            state           <= WAIT_SAMPLE;
                            cfg_coeff_ready <= 1'b0;
                        end else begin
                            count <= count + AW'(1);
                        end
                    end
                end
                WAIT_SAMPLE: begin
                    if (sample_strobe) begin
                        state         <= WRITE;
                        filter_enable <= 1'b0;
                        coef_wr_en    <= 1'b1;
                        coef_wr_data  <= shadow[0];
                    end
                end
                WRITE: begin
                    if (coef_wr_addr == LAST) begin
                        if (FLUSH_ON_UPDATE != 0) begin
                            state        <= FLUSH;
                            filter_flush <= 1'b1;
                        end else begin
                            state         <= DONE;
                            cfg_done      <= 1'b1;
                            filter_enable <= 1'b1;
                        end
                    end else begin
                        coef_wr_en   <= 1'b1;
                        coef_wr_addr <= next_addr;
                        coef_wr_data <= shadow[next_addr];
                    end
                end
                FLUSH: begin
                    state         <= DONE;
                    cfg_done      <= 1'b1;
                    filter_enable <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    cfg_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: a flushing and a non-flushing instance
// share one stimulus stream.
module tb_fir_coeff_ctrl;

    localparam int ORDER = 15;
    localparam int CW    = 32;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset, cfg_start, cfg_abort, cfg_coeff_valid, sample_strobe;
    logic [CW-1:0] cfg_coeff_data;

    logic          ready, busy, done, en, flush, wren;
    logic [AW-1:0] addr;
    logic [CW-1:0] wdata;
    logic          ready0, busy0, done0, en0, flush0, wren0;
    logic [AW-1:0] addr0;
    logic [CW-1:0] wdata0;

    always #5 clk = ~clk;

    fir_coeff_ctrl #(.ORDER(ORDER), .COEFF_WIDTH(CW), .FLUSH_ON_UPDATE(1)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_coeff_data(cfg_coeff_data), .cfg_coeff_valid(cfg_coeff_valid),
        .cfg_coeff_ready(ready), .cfg_busy(busy), .cfg_done(done),
        .sample_strobe(sample_strobe), .filter_enable(en), .filter_flush(flush),
        .coef_wr_en(wren), .coef_wr_addr(addr), .coef_wr_data(wdata)
    );

    fir_coeff_ctrl #(.ORDER(ORDER), .COEFF_WIDTH(CW), .FLUSH_ON_UPDATE(0)) dut0 (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_coeff_data(cfg_coeff_data), .cfg_coeff_valid(cfg_coeff_valid),
        .cfg_coeff_ready(ready0), .cfg_busy(busy0), .cfg_done(done0),
        .sample_strobe(sample_strobe), .filter_enable(en0), .filter_flush(flush0),
        .coef_wr_en(wren0), .coef_wr_addr(addr0), .coef_wr_data(wdata0)
    );

    typedef struct {
        int          c;
        int          a;
        logic [31:0] d;
    } wr_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    wr_t  wq[$];
    int   fq[$];
    int   dq[$];
    int   eq[$];
    int   dq0[$];
    int   wr0_cnt = 0;
    int   flush0_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wren) wq.push_back('{cyc, int'(addr), wdata});
        if (flush) fq.push_back(cyc);
        if (done) dq.push_back(cyc);
        if (!en) eq.push_back(cyc);
        if (done0) dq0.push_back(cyc);
        if (wren0) wr0_cnt++;
        if (flush0) flush0_cnt++;
        checks++;
        if (!wren && (addr != '0 || wdata != '0)) begin
            errors++;
            $display("FAIL idle_bus_zero: addr=%0h data=%0h required 0", addr, wdata);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cfg_start = 0; cfg_abort = 0; cfg_coeff_valid = 0;
        cfg_coeff_data = '0; sample_strobe = 0;
    endtask

    task automatic clear_logs();
        wq.delete(); fq.delete(); dq.delete(); eq.delete(); dq0.delete();
    endtask

    task automatic do_start();
        cfg_start = 1; tick(); cfg_start = 0;
    endtask

    task automatic load_beats(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            cfg_coeff_valid = 1; cfg_coeff_data = base + i; tick();
        end
        cfg_coeff_valid = 0; cfg_coeff_data = '0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60 && dq.size() == 0; i++) tick();
        chk({name, "_done_seen"}, 64'(dq.size()), 64'd1);
        tick();
    endtask

    task automatic check_writes(input string name, input int base, input int n0);
        chk({name, "_wr_count"}, 64'(wq.size()), 64'(ORDER));
        for (int i = 0; i < wq.size() && i < ORDER; i++) begin
            chk({name, "_wr_addr"}, 64'(wq[i].a), 64'(i));
            chk({name, "_wr_data"}, 64'(wq[i].d), 64'(base + i));
            if (n0 >= 0) chk({name, "_wr_cyc"}, 64'(wq[i].c), 64'(n0 + 1 + i));
        end
    endtask

    typedef struct {
        string       name;
        logic        rst, start, abort, valid, strobe;
        logic [31:0] data;
        logic        e_ready, e_busy, e_en, e_wren;
    } vec_t;

    vec_t tbl[7];
    int   n;

    initial begin
        tbl[0] = '{"reset",        1, 1, 0, 0, 0, 32'h0,  0, 0, 1, 0};
        tbl[1] = '{"abort_idle",   0, 0, 1, 0, 0, 32'h0,  0, 0, 1, 0};
        tbl[2] = '{"valid_idle",   0, 0, 0, 1, 1, 32'h63, 0, 0, 1, 0};
        tbl[3] = '{"start",        0, 1, 0, 0, 0, 32'h0,  1, 1, 1, 0};
        tbl[4] = '{"start_in_load",0, 1, 0, 1, 0, 32'h11, 1, 1, 1, 0};
        tbl[5] = '{"abort_load",   0, 0, 1, 1, 0, 32'h12, 0, 0, 1, 0};
        tbl[6] = '{"idle_after",   0, 0, 0, 0, 1, 32'h0,  0, 0, 1, 0};

        reset = 1; idle_in();
        tick(); tick();
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_wr_addr", 64'(addr), 64'd0);
        chk("rst_wr_data", 64'(wdata), 64'd0);

        for (int i = 0; i < 7; i++) begin
            reset = tbl[i].rst; cfg_start = tbl[i].start; cfg_abort = tbl[i].abort;
            cfg_coeff_valid = tbl[i].valid; sample_strobe = tbl[i].strobe;
            cfg_coeff_data = tbl[i].data;
            tick();
            chk({tbl[i].name, "_ready"}, 64'(ready), 64'(tbl[i].e_ready));
            chk({tbl[i].name, "_busy"}, 64'(busy), 64'(tbl[i].e_busy));
            chk({tbl[i].name, "_en"}, 64'(en), 64'(tbl[i].e_en));
            chk({tbl[i].name, "_wren"}, 64'(wren), 64'(tbl[i].e_wren));
        end
        reset = 0; idle_in(); tick();
        chk("tbl_no_writes", 64'(wq.size()), 64'd0);

        // Nominal update: beats 1..15, strobe three cycles after the last beat
        clear_logs();
        do_start();
        load_beats(1, ORDER);
        chk("a_ready_low", 64'(ready), 64'd0);
        chk("a_busy_wait", 64'(busy), 64'd1);
        tick(); tick();
        sample_strobe = 1; n = cyc; tick(); sample_strobe = 0;
        wait_done("a");
        check_writes("a", 1, n);
        chk("a_flush_cnt", 64'(fq.size()), 64'd1);
        if (fq.size() > 0) chk("a_flush_cyc", 64'(fq[0]), 64'(n + 16));
        if (dq.size() > 0) chk("a_done_cyc", 64'(dq[0]), 64'(n + 17));
        chk("a_en_low_cnt", 64'(eq.size()), 64'd16);
        if (eq.size() > 0) begin
            chk("a_en_low_first", 64'(eq[0]), 64'(n + 1));
            chk("a_en_low_last", 64'(eq[$]), 64'(n + 16));
        end
        chk("a0_done_cnt", 64'(dq0.size()), 64'd1);
        if (dq0.size() > 0) chk("a0_done_cyc", 64'(dq0[0]), 64'(n + 16));
        chk("a0_wr_cnt", 64'(wr0_cnt), 64'(ORDER));
        chk("a_idle_busy", 64'(busy), 64'd0);
        chk("a_idle_en", 64'(en), 64'd1);

        // Valid toggling every other cycle, then extra beats after LOAD
        clear_logs();
        do_start();
        for (int k = 0; k < 30; k++) begin
            cfg_coeff_valid = (k % 2 == 0);
            cfg_coeff_data = (k % 2 == 0) ? 32'(101 + k / 2) : 32'h0;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            cfg_coeff_valid = 1; cfg_coeff_data = 32'd999;
            chk("b_ready_extra", 64'(ready), 64'd0);
            tick();
        end
        cfg_coeff_valid = 0;
        sample_strobe = 1; n = cyc; tick(); sample_strobe = 0;
        wait_done("b");
        check_writes("b", 101, n);

        // Abort with the 8th beat, then a clean reload
        clear_logs();
        do_start();
        load_beats(200, 7);
        cfg_coeff_valid = 1; cfg_coeff_data = 32'hBAD; cfg_abort = 1;
        tick();
        idle_in();
        chk("c_abort_busy", 64'(busy), 64'd0);
        chk("c_abort_ready", 64'(ready), 64'd0);
        sample_strobe = 1; tick(); tick(); sample_strobe = 0; tick();
        chk("c_no_writes", 64'(wq.size()), 64'd0);
        do_start();
        load_beats(300, ORDER);
        sample_strobe = 1; n = cyc; tick(); sample_strobe = 0;
        wait_done("c");
        check_writes("c", 300, n);

        // Strobe on the final beat does not count
        clear_logs();
        do_start();
        load_beats(400, ORDER - 1);
        cfg_coeff_valid = 1; cfg_coeff_data = 32'(400 + ORDER - 1); sample_strobe = 1;
        tick();
        idle_in();
        for (int k = 0; k < 10; k++) tick();
        chk("d_no_writes", 64'(wq.size()), 64'd0);
        chk("d_busy_wait", 64'(busy), 64'd1);
        sample_strobe = 1; n = cyc; tick(); sample_strobe = 0;
        wait_done("d");
        check_writes("d", 400, n);

        // Reset during the 5th write; cfg_start during WRITE ignored
        clear_logs();
        do_start();
        load_beats(500, ORDER);
        sample_strobe = 1; n = cyc; tick(); sample_strobe = 0;
        cfg_start = 1; tick(); tick(); cfg_start = 0;
        tick(); tick();
        reset = 1; tick(); reset = 0;
        chk("e_rst_ready", 64'(ready), 64'd0);
        chk("e_rst_busy", 64'(busy), 64'd0);
        chk("e_rst_done", 64'(done), 64'd0);
        chk("e_rst_flush", 64'(flush), 64'd0);
        chk("e_rst_wren", 64'(wren), 64'd0);
        chk("e_rst_addr", 64'(addr), 64'd0);
        chk("e_rst_data", 64'(wdata), 64'd0);
        chk("e_rst_en", 64'(en), 64'd1);
        sample_strobe = 1;
        for (int k = 0; k < 20; k++) tick();
        sample_strobe = 0;
        chk("e_wr_count", 64'(wq.size()), 64'd5);
        if (wq.size() == 5) begin
            chk("e_last_addr", 64'(wq[4].a), 64'd4);
            chk("e_last_data", 64'(wq[4].d), 64'd504);
            chk("e_last_cyc", 64'(wq[4].c), 64'(n + 5));
        end
        chk("e_no_done", 64'(dq.size()), 64'd0);
        chk("e_no_flush", 64'(fq.size()), 64'd0);

        chk("nf_flush_never", 64'(flush0_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
